// File: rtl/wavelet_core_array.sv
// rtl/wavelet_core_array.sv - octave-spaced I/Q wavelet correlator array with serial readout
module wavelet_core_array #(
    parameter int NCH = 2,
    parameter int CW  = 8
) (
    input  logic           clk_master,
    input  logic           rstb,
    input  logic           ud_en,
    input  logic [NCH-1:0] comp_high_I,
    input  logic [NCH-1:0] comp_high_Q,
    output logic [NCH-1:0] tick_out,
    output logic [NCH-1:0] cos_out,
    output logic [NCH-1:0] sin_out,
    output logic           read_out_I,
    output logic           read_out_Q,
    output logic           read_valid,
    output logic           read_start,
    output logic           busy
);

    localparam int FW = NCH * CW;
    localparam int BW = (FW > 1) ? $clog2(FW) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [NCH-1:0]  div_cnt;
    logic [NCH-1:0]  tick;
    logic [1:0]      ph     [NCH];
    logic [CW-1:0]   corr_i [NCH];
    logic [CW-1:0]   corr_q [NCH];
    logic [FW-1:0]   sr_i, sr_q;
    logic [FW-1:0]   pack_i, pack_q;
    logic [BW-1:0]   bit_cnt;
    logic            ud_en_q;
    logic            rise, fall;
    logic            clear_corr, load_sr, acc_en;

    // Saturating +/-1 step; holds at the two's complement extremes instead of wrapping.
    function automatic logic [CW-1:0] sat_step(input logic [CW-1:0] v, input logic up);
        logic [CW-1:0] vmax;
        logic [CW-1:0] vmin;
        vmax = {1'b0, {(CW-1){1'b1}}};
        vmin = {1'b1, {(CW-1){1'b0}}};
        if (up)
            return (v == vmax) ? v : v + CW'(1);
        else
            return (v == vmin) ? v : v - CW'(1);
    endfunction

    // Channel k ticks when the low k+1 divider bits are all ones.
    for (genvar k = 0; k < NCH; k++) begin : g_tick
        assign tick[k]    = &div_cnt[k:0];
        assign cos_out[k] = ph[k][1];
        assign sin_out[k] = ph[k][0];
    end

    assign tick_out = tick;

    assign rise = ud_en & ~ud_en_q;
    assign fall = ~ud_en & ud_en_q;

    assign clear_corr = rise & ((state == IDLE) | (state == SHIFT));
    assign load_sr    = (state == ACCUM) & fall;
    assign acc_en     = (state == ACCUM) & ~fall;

    // Readout frame: channel 0 occupies the top of the shift register so it leaves first.
    always_comb begin
        pack_i = '0;
        pack_q = '0;
        for (int k = 0; k < NCH; k++) begin
            pack_i[(NCH-1-k)*CW +: CW] = corr_i[k];
            pack_q[(NCH-1-k)*CW +: CW] = corr_q[k];
        end
    end

    // Readout FSM next-state: a rise during SHIFT aborts straight back to accumulation.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (rise) state_n = ACCUM;
            ACCUM:   if (fall) state_n = SHIFT;
            SHIFT: begin
                if (rise)
                    state_n = ACCUM;
                else if (bit_cnt == BW'(FW - 1))
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register, edge detector and free-running divider.
    always_ff @(posedge clk_master) begin
        if (!rstb) begin
            state   <= IDLE;
            ud_en_q <= 1'b0;
            div_cnt <= '0;
        end else begin
            state   <= state_n;
            ud_en_q <= ud_en;
            div_cnt <= div_cnt + NCH'(1);
        end
    end

    // LO phases advance in Gray order on each channel tick, regardless of the FSM.
    always_ff @(posedge clk_master) begin
        for (int k = 0; k < NCH; k++) begin
            if (!rstb)
                ph[k] <= 2'b00;
            else if (tick[k])
                ph[k] <= {ph[k][0], ~ph[k][1]};
        end
    end

    // Correlators compare against the pre-update LO and freeze outside accumulation.
    always_ff @(posedge clk_master) begin
        for (int k = 0; k < NCH; k++) begin
            if (!rstb || clear_corr) begin
                corr_i[k] <= '0;
                corr_q[k] <= '0;
            end else if (acc_en && tick[k]) begin
                corr_i[k] <= sat_step(corr_i[k], comp_high_I[k] == ph[k][1]);
                corr_q[k] <= sat_step(corr_q[k], comp_high_Q[k] == ph[k][0]);
            end
        end
    end

    // Snapshot on fall, then shift MSB-first one bit per cycle while in SHIFT.
    always_ff @(posedge clk_master) begin
        if (!rstb) begin
            sr_i    <= '0;
            sr_q    <= '0;
            bit_cnt <= '0;
        end else if (load_sr) begin
            sr_i    <= pack_i;
            sr_q    <= pack_q;
            bit_cnt <= '0;
        end else if (state == SHIFT) begin
            sr_i    <= sr_i << 1;
            sr_q    <= sr_q << 1;
            bit_cnt <= bit_cnt + BW'(1);
        end
    end

    assign read_valid = (state == SHIFT);
    assign busy       = (state == SHIFT);
    assign read_start = (state == SHIFT) && (bit_cnt == '0);
    assign read_out_I = (state == SHIFT) & sr_i[FW-1];
    assign read_out_Q = (state == SHIFT) & sr_q[FW-1];

endmodule

// File: tb/tb_wavelet_core_array.sv
// tb/tb_wavelet_core_array.sv - directed self-checking bench for wavelet_core_array (NCH=2, CW=4)
module tb_wavelet_core_array;

    logic       clk_master = 1'b0;
    logic       rstb;
    logic       ud_en;
    logic [1:0] comp_high_I;
    logic [1:0] comp_high_Q;
    logic [1:0] tick_out;
    logic [1:0] cos_out;
    logic [1:0] sin_out;
    logic       read_out_I;
    logic       read_out_Q;
    logic       read_valid;
    logic       read_start;
    logic       busy;

    int tests = 0;
    int fails = 0;

    logic [1:0] exp_tick [8];
    logic [1:0] exp_cs   [8];

    wavelet_core_array #(.NCH(2), .CW(4)) dut (
        .clk_master  (clk_master),
        .rstb        (rstb),
        .ud_en       (ud_en),
        .comp_high_I (comp_high_I),
        .comp_high_Q (comp_high_Q),
        .tick_out    (tick_out),
        .cos_out     (cos_out),
        .sin_out     (sin_out),
        .read_out_I  (read_out_I),
        .read_out_Q  (read_out_Q),
        .read_valid  (read_valid),
        .read_start  (read_start),
        .busy        (busy)
    );

    always #5 clk_master = ~clk_master;

    task automatic step();
        @(posedge clk_master);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check(tag, {tick_out, cos_out, sin_out, read_out_I, read_out_Q, read_valid, read_start, busy}, 16'h0);
    endtask

    // mode 0: comparators follow the LO; 1: I=1, Q=0; 2: comparators oppose the LO
    task automatic accumulate(input int n_ticks, input int mode);
        int cnt = 0;
        int budget = 0;
        while (cnt < n_ticks && budget < 200) begin
            case (mode)
                0:       begin comp_high_I = cos_out;  comp_high_Q = sin_out;  end
                1:       begin comp_high_I = 2'b11;    comp_high_Q = 2'b00;    end
                default: begin comp_high_I = ~cos_out; comp_high_Q = ~sin_out; end
            endcase
            if (tick_out[0]) cnt++;
            step();
            budget++;
        end
        check("accum_budget", 16'(cnt), 16'(n_ticks));
    endtask

    task automatic readout(input string tag, input logic [7:0] ei, input logic [7:0] eq);
        logic [7:0] got_i;
        logic [7:0] got_q;
        int nvalid = 0;
        int nstart = 0;
        logic start_first = 1'b0;
        for (int i = 0; i < 8; i++) begin
            got_i[7-i] = read_out_I;
            got_q[7-i] = read_out_Q;
            if (read_valid && busy) nvalid++;
            if (read_start) nstart++;
            if (i == 0) start_first = read_start;
            step();
        end
        check({tag, "_valid_cnt"}, 16'(nvalid), 16'd8);
        check({tag, "_start_cnt"}, {15'd0, start_first}, 16'd1);
        check({tag, "_start_once"}, 16'(nstart), 16'd1);
        check({tag, "_bits_I"}, {8'd0, got_i}, {8'd0, ei});
        check({tag, "_bits_Q"}, {8'd0, got_q}, {8'd0, eq});
        check({tag, "_done"}, {14'd0, read_valid, busy}, 16'd0);
    endtask

    initial begin
        exp_tick = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00, 2'b11};
        exp_cs   = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b10};

        rstb = 1'b0;
        ud_en = 1'b0;
        comp_high_I = 2'b00;
        comp_high_Q = 2'b00;
        step();
        step();
        check_idle_outputs("reset_outputs");

        // divider ticks and LO Gray sequence
        rstb = 1'b1;
        for (int c = 0; c < 8; c++) begin
            check($sformatf("tick_c%0d", c), {14'd0, tick_out}, {14'd0, exp_tick[c]});
            check($sformatf("lo0_c%0d", c), {14'd0, cos_out[0], sin_out[0]}, {14'd0, exp_cs[c]});
            step();
        end

        // saturation to +7 on both channels
        ud_en = 1'b1;
        step();
        accumulate(20, 0);
        ud_en = 1'b0;
        step();
        readout("sat_pos", 8'b0111_0111, 8'b0111_0111);

        // constant comparator input balances to 0
        ud_en = 1'b1;
        step();
        accumulate(16, 1);
        ud_en = 1'b0;
        step();
        readout("balanced", 8'b0000_0000, 8'b0000_0000);

        // opposed comparator saturates at -8
        ud_en = 1'b1;
        step();
        accumulate(16, 2);
        ud_en = 1'b0;
        step();
        readout("sat_neg", 8'b1000_1000, 8'b1000_1000);

        // abort 3 cycles into SHIFT
        ud_en = 1'b1;
        step();
        accumulate(8, 0);
        ud_en = 1'b0;
        step();
        check("abort_shift1", {14'd0, read_valid, read_start}, 16'b11);
        step();
        step();
        check("abort_shift3", {14'd0, read_valid, read_start}, 16'b10);
        ud_en = 1'b1;
        step();
        check("abort_drop", {13'd0, read_valid, read_start, busy}, 16'd0);
        ud_en = 1'b0;
        step();
        readout("abort_clear", 8'b0000_0000, 8'b0000_0000);

        // reset mid-ACCUM
        ud_en = 1'b1;
        step();
        accumulate(6, 0);
        rstb = 1'b0;
        step();
        check_idle_outputs("midreset_outputs");
        rstb = 1'b1;
        ud_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("post_reset_idle%0d", c), {14'd0, read_valid, busy}, 16'd0);
            step();
        end
        ud_en = 1'b1;
        step();
        accumulate(4, 0);
        ud_en = 1'b0;
        step();
        readout("resume", 8'b0100_0010, 8'b0100_0010);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
